// File: rtl/muon_pulse_trigger.sv
// Threshold-crossing trigger for the circular-capture stage on the ADC clock.
// Fires on a single pulse, or on a pulse pair whose spacing falls inside [min_gap, max_gap].
module muon_pulse_trigger #(
  parameter int TRIG_WIDTH = 4,
  parameter int GAP_W      = 16
) (
  input  logic             clka,
  input  logic             int_rst,
  input  logic [13:0]      adc_data,
  input  logic [13:0]      threshold,
  input  logic             polarity,
  input  logic             dbl_mode,
  input  logic             arm,
  input  logic [GAP_W-1:0] min_gap,
  input  logic [GAP_W-1:0] max_gap,
  input  logic [GAP_W-1:0] holdoff,
  output logic             trig,
  output logic [GAP_W-1:0] decay_time,
  output logic [31:0]      pulse_cnt,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FIRST,
    WAIT_SECOND,
    FIRE,
    HOLDOFF
  } state_t;

  localparam logic [GAP_W-1:0] FIRE_LAST = GAP_W'(TRIG_WIDTH - 1);

  state_t             state;
  logic [13:0]        s1;
  logic               above;
  logic               above_d;
  logic [GAP_W-1:0]   cnt;

  logic signed [14:0] s1_ext;
  logic signed [14:0] s1_pol;
  logic signed [14:0] thr_ext;
  logic               edge_det;
  logic [GAP_W-1:0]   cnt_inc;
  logic               in_window;
  logic               timeout;
  logic               hold_done;

  // 15-bit signed compare so that negating -8192 yields +8192 without wrapping.
  // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
  always_comb begin
    s1_ext    = {s1[13], s1};
    s1_pol    = polarity ? -s1_ext : s1_ext;
    thr_ext   = {threshold[13], threshold};
    edge_det  = above & ~above_d;
    cnt_inc   = cnt + GAP_W'(1);
    in_window = (cnt_inc >= min_gap) && (cnt_inc <= max_gap);
    timeout   = cnt_inc >= max_gap;
    hold_done = cnt_inc >= holdoff;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clka or posedge int_rst) begin
    if (int_rst) begin
      s1      <= '0;
      above   <= 1'b0;
      above_d <= 1'b0;
    end else begin
      s1      <= adc_data;
      above   <= s1_pol >= thr_ext;
      above_d <= above;
    end
  end

  // cnt is shared: inter-pulse gap in WAIT_SECOND (cnt_inc = cycles since first edge),
  // trig length in FIRE, dead time in HOLDOFF.
  always_ff @(posedge clka or posedge int_rst) begin
    if (int_rst) begin
      state      <= IDLE;
      cnt        <= '0;
      trig       <= 1'b0;
      busy       <= 1'b0;
      decay_time <= '0;
    end else if (!arm) begin
      state <= IDLE;
      cnt   <= '0;
      trig  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= WAIT_FIRST;
        end
        WAIT_FIRST: begin
          if (edge_det) begin
            cnt  <= '0;
            busy <= 1'b1;
            if (dbl_mode) begin
              state <= WAIT_SECOND;
            end else begin
              state      <= FIRE;
              trig       <= 1'b1;
              decay_time <= '0;
            end
          end
        end
        WAIT_SECOND: begin
          // An edge landing on gap == max_gap wins over the timeout.
          if (edge_det && in_window) begin
            state      <= FIRE;
            trig       <= 1'b1;
            decay_time <= cnt_inc;
            cnt        <= '0;
          end else if (timeout) begin
            state <= WAIT_FIRST;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        FIRE: begin
          if (cnt == FIRE_LAST) begin
            trig <= 1'b0;
            cnt  <= '0;
            if (holdoff != '0) begin
              state <= HOLDOFF;
            end else begin
              state <= WAIT_FIRST;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt_inc;
          end
        end
        HOLDOFF: begin
          if (hold_done) begin
            state <= WAIT_FIRST;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          trig  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Edges are counted in every non-idle state, including FIRE and HOLDOFF.
  always_ff @(posedge clka or posedge int_rst) begin
    if (int_rst) begin
      pulse_cnt <= '0;
    end else if (edge_det && (state != IDLE)) begin
      pulse_cnt <= pulse_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_muon_pulse_trigger.sv
// Directed bench for muon_pulse_trigger: expected triggers are queued as stimulus is driven
// and matched by a monitor on each rising trig; counters and status are checked inline.
module tb_muon_pulse_trigger;

  localparam int TRIG_WIDTH = 4;
  localparam int GAP_W      = 16;

  typedef struct {
    int               cyc;
    logic [GAP_W-1:0] decay;
  } exp_t;

  logic             clka;
  logic             int_rst;
  logic [13:0]      adc_data;
  logic [13:0]      threshold;
  logic             polarity;
  logic             dbl_mode;
  logic             arm;
  logic [GAP_W-1:0] min_gap;
  logic [GAP_W-1:0] max_gap;
  logic [GAP_W-1:0] holdoff;
  logic             trig;
  logic [GAP_W-1:0] decay_time;
  logic [31:0]      pulse_cnt;
  logic             busy;

  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   exp_cnt     = 0;
  int   t0;
  exp_t sb[$];

  muon_pulse_trigger #(.TRIG_WIDTH(TRIG_WIDTH), .GAP_W(GAP_W)) dut (
    .clka       (clka),
    .int_rst    (int_rst),
    .adc_data   (adc_data),
    .threshold  (threshold),
    .polarity   (polarity),
    .dbl_mode   (dbl_mode),
    .arm        (arm),
    .min_gap    (min_gap),
    .max_gap    (max_gap),
    .holdoff    (holdoff),
    .trig       (trig),
    .decay_time (decay_time),
    .pulse_cnt  (pulse_cnt),
    .busy       (busy)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  always @(posedge clka) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clka);
    #1;
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) tick(1);
  endtask

  // One-cycle sample, then back to a quiet baseline of 0.
  task automatic pulse(input logic [13:0] v, input bit counts);
    adc_data = v;
    if (counts) exp_cnt++;
    tick(1);
    adc_data = 14'd0;
  endtask

  // Trigger monitor: each rising trig must match the head of the scoreboard,
  // and each completed trig must last exactly TRIG_WIDTH cycles.
  logic trig_prev = 1'b0;
  int   hi_len    = 0;
  always @(negedge clka) begin
    exp_t e;
    if (int_rst) begin
      trig_prev = 1'b0;
      hi_len    = 0;
    end else begin
      if (trig && !trig_prev) begin
        check("trig_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("trig_start_cycle", 64'(cyc), 64'(e.cyc));
          check("trig_decay_time", 64'(decay_time), 64'(e.decay));
        end
        hi_len = 1;
      end else if (trig) begin
        hi_len++;
      end else if (trig_prev) begin
        check("trig_width", 64'(hi_len), 64'(TRIG_WIDTH));
      end
      trig_prev = trig;
    end
  end

  initial begin
    int_rst   = 1'b1;
    arm       = 1'b0;
    adc_data  = 14'd0;
    threshold = 14'd1000;
    polarity  = 1'b0;
    dbl_mode  = 1'b0;
    min_gap   = 16'd10;
    max_gap   = 16'd200;
    holdoff   = 16'd0;
    tick(2);
    check("rst_trig", 64'(trig), 64'd0);
    check("rst_decay", 64'(decay_time), 64'd0);
    check("rst_pulse_cnt", 64'(pulse_cnt), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    int_rst = 1'b0;
    tick(1);
    arm = 1'b1;
    tick(2);

    // Single mode: sub-threshold sample, then a crossing; trig starts 3 cycles after the sample.
    adc_data = 14'd500;
    tick(1);
    t0 = cyc;
    sb.push_back('{t0 + 3, 16'd0});
    pulse(14'd1200, 1'b1);
    tick(10);
    check("single_pulse_cnt", 64'(pulse_cnt), 64'(exp_cnt));
    check("single_decay", 64'(decay_time), 64'd0);
    check("single_busy_after", 64'(busy), 64'd0);

    // Double mode: pair 100 cycles apart fires with decay 100.
    arm = 1'b0; tick(1);
    dbl_mode = 1'b1; arm = 1'b1; tick(2);
    t0 = cyc;
    pulse(14'd2000, 1'b1);
    wait_to(t0 + 100);
    sb.push_back('{t0 + 103, 16'd100});
    pulse(14'd2000, 1'b1);
    tick(10);
    check("dbl_decay_100", 64'(decay_time), 64'd100);
    check("dbl_busy_after", 64'(busy), 64'd0);

    // Gap 5 is too short and ignored; the window then times out at 200.
    t0 = cyc;
    pulse(14'd2000, 1'b1);
    wait_to(t0 + 5);
    pulse(14'd2000, 1'b1);
    wait_to(t0 + 150);
    check("dbl_short_gap_window_open", 64'(busy), 64'd1);
    wait_to(t0 + 250);
    check("dbl_window_timeout", 64'(busy), 64'd0);
    wait_to(t0 + 300);
    pulse(14'd2000, 1'b1);
    tick(3);
    check("dbl_late_pulse_new_first", 64'(busy), 64'd1);
    tick(210);
    check("dbl_late_pulse_timeout", 64'(busy), 64'd0);
    check("dbl_pulse_cnt", 64'(pulse_cnt), 64'(exp_cnt));
    check("dbl_decay_held", 64'(decay_time), 64'd100);

    // Window boundaries with min=20, max=50.
    arm = 1'b0; tick(1);
    min_gap = 16'd20; max_gap = 16'd50; arm = 1'b1; tick(2);
    t0 = cyc;
    pulse(14'd2000, 1'b1);
    wait_to(t0 + 50);
    sb.push_back('{t0 + 53, 16'd50});
    pulse(14'd2000, 1'b1);
    tick(10);
    check("win_max_decay", 64'(decay_time), 64'd50);
    t0 = cyc;
    pulse(14'd2000, 1'b1);
    wait_to(t0 + 51);
    pulse(14'd2000, 1'b1);
    tick(60);
    check("win_max_plus1_no_trig", 64'(busy), 64'd0);
    t0 = cyc;
    pulse(14'd2000, 1'b1);
    wait_to(t0 + 20);
    sb.push_back('{t0 + 23, 16'd20});
    pulse(14'd2000, 1'b1);
    tick(10);
    check("win_min_decay", 64'(decay_time), 64'd20);

    // Negative polarity: -8192 and -1000 are detected, +8191 is not.
    arm = 1'b0; tick(1);
    polarity = 1'b1; dbl_mode = 1'b0; arm = 1'b1; tick(2);
    t0 = cyc;
    sb.push_back('{t0 + 3, 16'd0});
    pulse(14'h2000, 1'b1);
    tick(10);
    check("neg_decay_zero", 64'(decay_time), 64'd0);
    pulse(14'h1FFF, 1'b0);
    tick(10);
    check("neg_pos_max_ignored", 64'(pulse_cnt), 64'(exp_cnt));
    t0 = cyc;
    sb.push_back('{t0 + 3, 16'd0});
    pulse(-14'sd1000, 1'b1);
    tick(10);
    check("neg_thr_equal", 64'(pulse_cnt), 64'(exp_cnt));

    // Holdoff of 50: edges inside it count but never fire; the first free cycle fires.
    arm = 1'b0; tick(1);
    polarity = 1'b0; holdoff = 16'd50; arm = 1'b1; tick(2);
    t0 = cyc;
    sb.push_back('{t0 + 3, 16'd0});
    pulse(14'd2000, 1'b1);
    wait_to(t0 + 20);
    pulse(14'd2000, 1'b1);
    wait_to(t0 + 30);
    check("holdoff_busy", 64'(busy), 64'd1);
    wait_to(t0 + 40);
    pulse(14'd2000, 1'b1);
    wait_to(t0 + 55);
    sb.push_back('{t0 + 58, 16'd0});
    pulse(14'd2000, 1'b1);
    tick(10);
    check("holdoff_pulse_cnt", 64'(pulse_cnt), 64'(exp_cnt));

    // Dropping arm in WAIT_SECOND returns to IDLE on the next edge.
    arm = 1'b0; tick(60);
    holdoff = 16'd0; dbl_mode = 1'b1; min_gap = 16'd10; max_gap = 16'd200;
    arm = 1'b1; tick(2);
    pulse(14'd2000, 1'b1);
    tick(5);
    check("arm_drop_wait_second", 64'(busy), 64'd1);
    arm = 1'b0;
    tick(1);
    check("arm_drop_idle", 64'(busy), 64'd0);
    check("arm_drop_pulse_cnt", 64'(pulse_cnt), 64'(exp_cnt));

    // Asynchronous reset in the middle of a trig.
    dbl_mode = 1'b0; arm = 1'b1; tick(2);
    t0 = cyc;
    sb.push_back('{t0 + 3, 16'd0});
    pulse(14'd2000, 1'b1);
    wait_to(t0 + 4);
    check("mid_fire_trig", 64'(trig), 64'd1);
    #2;
    int_rst = 1'b1;
    #1;
    check("rst_mid_fire_trig", 64'(trig), 64'd0);
    check("rst_mid_fire_pulse_cnt", 64'(pulse_cnt), 64'd0);
    check("rst_mid_fire_busy", 64'(busy), 64'd0);
    exp_cnt = 0;
    tick(2);
    int_rst = 1'b0;
    tick(5);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
